spi_serf: RTL and testbench
===========================

// Module: spi_serf
// PURPOSE
//  SPI responder (serf): far end of the on-chip 16-bit SPI monarch link. Synchronizes SS_n/SCLK/MOSI,
//  receives one frame per SS_n-low window, returns tx_data on MISO, and pulses rdy with the received word.
//  Serves as a sensor/A2D bench model and as the inter-block SPI target. SCLK idles high.
//  Monarch changes MOSI just after SCLK rise and samples MISO shortly after SCLK rise.
// PARAMETERS
//  FRAME_W      16  bits per frame
//  SYNC_STAGES  2   metastability flops on SS_n, SCLK, MOSI (>=2)
// PORTS
//  clk      in   1        system clock, single clock domain
//  rst_n    in   1        synchronous active-low reset
//  SS_n     in   1        async select from monarch, active low
//  SCLK     in   1        async serial clock, idles high, period >= 8 clk
//  MOSI     in   1        async serial data in, MSB first
//  MISO     out  1        serial data out, MSB first
//  tx_data  in   FRAME_W  response word, captured on the SS_n falling edge
//  rx_data  out  FRAME_W  last complete received frame
//  rdy      out  1        1-clk pulse: rx_data updated
// BEHAVIOUR
//  Reset (rst_n low at posedge clk): state=IDLE, MISO=0, rx_data=0, rdy=0, bit_cnt=0, all sync flops=1.
//  Edges: ss_fall/ss_rise/sclk_rise/sclk_fall from last two sync stages; MOSI delayed identically (aligned).
//  FSM (spi_pkg::serf_state_t): IDLE, XFER.
//   IDLE: on ss_fall -> XFER; shft_reg<=tx_data, bit_cnt<=0, rise_seen<=0.
//   XFER: sclk_rise -> smpl<=MOSI_sync, bit_cnt<=sat(bit_cnt+1), rise_seen<=1.
//         sclk_fall & rise_seen -> shft_reg<={shft_reg[FRAME_W-2:0],smpl}.
//         sclk_fall before first rise (initial SCLK drop) ignored.
//         ss_rise -> IDLE; if bit_cnt==FRAME_W: rx_data<={shft_reg[FRAME_W-2:0],smpl}, rdy=1 next clk.
//         Otherwise frame discarded, rx_data unchanged, no rdy.
//  MISO = shft_reg[FRAME_W-1] in XFER, 0 in IDLE; first bit valid before the first SCLK rise.
//  MISO changes only on sclk_fall, so it is stable at every monarch sample point.
//  Latency: rdy asserts SYNC_STAGES+2 clk after SS_n rises (pin-level).
//  bit_cnt width $clog2(FRAME_W+1)+1, saturates; >FRAME_W rises = invalid frame.
//  Simultaneous ss_rise & sclk edge: ss_rise wins; the SCLK edge is ignored.
//  ss_fall same cycle as rdy: both proceed; new tx_data captured, rdy pulse unaffected.
//  Reset mid-frame: abort, IDLE, no rdy; next frame requires a fresh ss_fall.
// CONFIGURATION
//  SPI_SERF_FRAME_ERR_EN defined: adds output frm_err (1 bit, reset 0), 1-clk pulse on ss_rise with
//   bit_cnt!=FRAME_W (short, long, or aborted frame), plus 8-bit saturating err_cnt output (reset 0).
//  Undefined: ports frm_err/err_cnt absent; bad frames silently dropped.
// STRUCTURE
//  spi_pkg: serf_state_t enum, SPI_FRAME_W=16 constant, SPI_SYNC_STAGES=2 default.
//  Sub-module sync_edge_det (SYNC_STAGES chain + rise/fall pulse, reset value 1): instanced for SS_n, SCLK.
//  MOSI uses the same chain length with no edge outputs; FSM, shift register and bit counter live in top.
// TESTING
//  Bench monarch at SCLK=clk/32, tx_data=16'hA5C3, monarch cmd=16'h3C5A -> rdy once, rx_data=16'h3C5A;
//   monarch resp=16'hA5C3.
//  Back-to-back frames (2 clk gap) 16'h0001 then 16'hFFFF -> two rdy pulses, rx_data values in order.
//  SS_n low with only 15 SCLK pulses -> no rdy, rx_data holds previous; frm_err=1 when macro defined.
//  rst_n low for 1 clk after 8 bits -> no rdy, MISO=0; next full 16'h1234 frame received correctly.
//  tx_data changed mid-frame (16'h0F0F -> 16'hF0F0) -> MISO stream still 16'h0F0F.
//  Min SCLK period 8 clk, frame 16'hBEEF -> rx_data=16'hBEEF, MISO data matches tx_data.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and defaults for the on-chip SPI link.
//   serf_state_t    : responder FSM states (IDLE, XFER)
//   SPI_FRAME_W     : bits per SPI frame (16)
//   SPI_SYNC_STAGES : default metastability chain length (2)
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } serf_state_t;

  localparam int SPI_FRAME_W     = 16;
  localparam int SPI_SYNC_STAGES = 2;

endpackage : spi_pkg

// File: rtl/spi_serf_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings one asynchronous level into the clk domain through a STAGES-deep
// flop chain, then flags single-cycle rising/falling edges of the synchronized
// level. All flops reset to 1 so an idle-high line produces no edge at reset.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   din   in  asynchronous input level
//   rise  out 1-clk pulse on a synchronized 0->1 transition
//   fall  out 1-clk pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edges compare the settled chain output against its one-clock-old copy.
  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule : sync_edge_det

// File: rtl/spi_serf.sv
// -----------------------------------------------------------------------------
// spi_serf
// SPI responder: far end of the 16-bit SPI monarch link. Synchronizes SS_n,
// SCLK and MOSI, receives one frame per SS_n-low window, returns tx_data on
// MISO (MSB first) and pulses rdy once rx_data holds a complete frame.
// SCLK idles high; the monarch drives MOSI after SCLK rises and samples MISO
// shortly after SCLK rises, so MISO only moves on SCLK falls.
//
// Optional feature macro: SPI_SERF_FRAME_ERR_EN
//   defined   -> frm_err pulse + 8-bit saturating err_cnt for bad frames
//   undefined -> bad frames are silently dropped, ports absent
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   SS_n     in   async select, active low
//   SCLK     in   async serial clock, idles high
//   MOSI     in   async serial data in, MSB first
//   MISO     out  serial data out, MSB first
//   tx_data  in   response word, captured when SS_n falls
//   rx_data  out  last complete received frame
//   rdy      out  1-clk pulse after rx_data is updated
//   frm_err  out  (macro) 1-clk pulse on a frame with wrong bit count
//   err_cnt  out  (macro) saturating count of bad frames
// -----------------------------------------------------------------------------
module spi_serf
  import spi_pkg::*;
#(
  parameter int FRAME_W     = SPI_FRAME_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [FRAME_W-1:0] tx_data,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rdy
`ifdef SPI_SERF_FRAME_ERR_EN
  ,
  output logic               frm_err,
  output logic [7:0]         err_cnt
`endif
);

  // One extra bit beyond FRAME_W so an over-long frame never wraps back to a
  // "valid" count.
  localparam int               CNT_W    = $clog2(FRAME_W + 1) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef SPI_SERF_FRAME_ERR_EN
  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic ss_rise;
  logic ss_fall;
  logic sclk_rise;
  logic sclk_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // MOSI goes through the same chain depth, so its last stage lines up with
  // the SCLK level that produced sclk_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_d;
  logic                   mosi_sync;

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM, shift register, bit counter
  // ---------------------------------------------------------------------------
  serf_state_t        state_q,     state_d;
  logic [FRAME_W-1:0] shft_q,      shft_d;
  logic               smpl_q,      smpl_d;
  logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic               rise_seen_q, rise_seen_d;
  logic [FRAME_W-1:0] rx_data_q,   rx_data_d;
  logic               rdy_pend_q,  rdy_pend_d;
  logic               rdy_q,       rdy_d;
  logic               miso_q,      miso_d;
  logic               bad_frame;
`ifdef SPI_SERF_FRAME_ERR_EN
  logic               frm_err_q,   frm_err_d;
  logic [7:0]         err_cnt_q,   err_cnt_d;
`endif

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};

    state_d     = state_q;
    shft_d      = shft_q;
    smpl_d      = smpl_q;
    bit_cnt_d   = bit_cnt_q;
    rise_seen_d = rise_seen_q;
    rx_data_d   = rx_data_q;
    rdy_pend_d  = 1'b0;
    rdy_d       = rdy_pend_q;
    bad_frame   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = XFER;
          shft_d      = tx_data;
          bit_cnt_d   = '0;
          rise_seen_d = 1'b0;
        end
      end
      XFER: begin
        // ss_rise has priority: a coincident SCLK edge is dropped.
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == FULL_CNT) begin
            // Last sampled bit never sees an SCLK fall, so append it here.
            rx_data_d  = {shft_q[FRAME_W-2:0], smpl_q};
            rdy_pend_d = 1'b1;
          end else begin
            bad_frame = 1'b1;
          end
        end else if (sclk_rise) begin
          smpl_d      = mosi_sync;
          bit_cnt_d   = sat_inc_cnt(bit_cnt_q);
          rise_seen_d = 1'b1;
        end else if (sclk_fall && rise_seen_q) begin
          // The initial SCLK drop after select is not a shift edge.
          shft_d = {shft_q[FRAME_W-2:0], smpl_q};
        end
      end
      default: state_d = IDLE;
    endcase

    miso_d = (state_d == XFER) ? shft_d[FRAME_W-1] : 1'b0;

`ifdef SPI_SERF_FRAME_ERR_EN
    frm_err_d = bad_frame;
    err_cnt_d = bad_frame ? sat_inc_err(err_cnt_q) : err_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    // Pure datapath holding registers; contents are don't-care in IDLE.
    shft_q <= shft_d;
    smpl_q <= smpl_d;
    if (!rst_n) begin
      mosi_sync_q <= '1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rise_seen_q <= 1'b0;
      rx_data_q   <= '0;
      rdy_pend_q  <= 1'b0;
      rdy_q       <= 1'b0;
      miso_q      <= 1'b0;
`ifdef SPI_SERF_FRAME_ERR_EN
      frm_err_q   <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rise_seen_q <= rise_seen_d;
      rx_data_q   <= rx_data_d;
      rdy_pend_q  <= rdy_pend_d;
      rdy_q       <= rdy_d;
      miso_q      <= miso_d;
`ifdef SPI_SERF_FRAME_ERR_EN
      frm_err_q   <= frm_err_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign MISO    = miso_q;
  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
`ifdef SPI_SERF_FRAME_ERR_EN
  assign frm_err = frm_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule : spi_serf

// File: tb/tb_spi_serf.sv
// -----------------------------------------------------------------------------
// tb_spi_serf
// Directed bench for spi_serf: a behavioural SPI monarch drives SS_n/SCLK/MOSI
// and captures MISO; rdy/rx_data (and frm_err when enabled) are logged by a
// monitor on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_serf;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rdy;
`ifdef SPI_SERF_FRAME_ERR_EN
  logic        frm_err;
  logic [7:0]  err_cnt;
  int          frm_err_cnt;
`endif

  int          checks;
  int          failures;
  int          rdy_cnt;
  logic [15:0] rx_log[$];

  spi_serf dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .rdy    (rdy)
`ifdef SPI_SERF_FRAME_ERR_EN
    ,
    .frm_err(frm_err),
    .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: rdy is a one-clock pulse, so the falling edge sees it exactly once.
  always @(negedge clk) begin
    if (rdy) begin
      rdy_cnt++;
      rx_log.push_back(rx_data);
    end
`ifdef SPI_SERF_FRAME_ERR_EN
    if (frm_err) frm_err_cnt++;
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monarch: select, initial SCLK drop, then nrises rise/fall pairs ending with
  // SCLK high. MISO is captured just after each SCLK rise.
  task automatic spi_xfer(input logic [15:0] cmd, input int half, input int nrises,
                          input int chg_bit, input logic [15:0] chg_val,
                          output logic [15:0] resp);
    resp = '0;
    SS_n = 1'b0;
    tick(half);
    for (int i = 0; i < nrises; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      if (i == chg_bit) tx_data = chg_val;
      tick(half);
      SCLK = 1'b1;
      #1;
      resp[15-i] = MISO;
      tick(half);
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (MISO !== 1'b0) begin
      failures++;
      $display("FAIL reset_miso got=%b exp=0", MISO);
    end
    checks++;
    if (rx_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rx_data got=%h exp=0000", rx_data);
    end
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy got=%b exp=0", rdy);
    end
`ifdef SPI_SERF_FRAME_ERR_EN
    checks++;
    if (frm_err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_err got=%b/%0d exp=0/0", frm_err, err_cnt);
    end
`endif
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    logic [15:0] resp;
    int          start;
    int          lat;
    start   = rdy_cnt;
    tx_data = 16'hA5C3;
    tick(2);
    spi_xfer(16'h3C5A, 16, 16, -1, 16'h0, resp);
    end_frame();
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      if (rdy === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL basic_rdy_latency got=%0d exp=4 (0 = timeout)", lat);
    end
    tick(10);
    checks++;
    if (rdy_cnt - start != 1) begin
      failures++;
      $display("FAIL basic_rdy_count got=%0d exp=1", rdy_cnt - start);
    end
    checks++;
    if (rx_data !== 16'h3C5A) begin
      failures++;
      $display("FAIL basic_rx_data got=%h exp=3c5a", rx_data);
    end
    checks++;
    if (resp !== 16'hA5C3) begin
      failures++;
      $display("FAIL basic_miso_resp got=%h exp=a5c3", resp);
    end
    checks++;
    if (MISO !== 1'b0) begin
      failures++;
      $display("FAIL basic_miso_idle got=%b exp=0", MISO);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] resp;
    int          start;
    start   = rdy_cnt;
    tx_data = 16'h1111;
    spi_xfer(16'h0001, 16, 16, -1, 16'h0, resp);
    end_frame();
    tick(2);
    spi_xfer(16'hFFFF, 16, 16, -1, 16'h0, resp);
    end_frame();
    tick(12);
    checks++;
    if (rdy_cnt - start != 2) begin
      failures++;
      $display("FAIL b2b_rdy_count got=%0d exp=2", rdy_cnt - start);
    end else begin
      checks++;
      if (rx_log[start] !== 16'h0001) begin
        failures++;
        $display("FAIL b2b_first got=%h exp=0001", rx_log[start]);
      end
      checks++;
      if (rx_log[start+1] !== 16'hFFFF) begin
        failures++;
        $display("FAIL b2b_second got=%h exp=ffff", rx_log[start+1]);
      end
    end
    checks++;
    if (rx_data !== 16'hFFFF) begin
      failures++;
      $display("FAIL b2b_rx_data got=%h exp=ffff", rx_data);
    end
  endtask

  task automatic test_short_frame();
    logic [15:0] resp;
    int          start;
`ifdef SPI_SERF_FRAME_ERR_EN
    int          estart;
    estart = frm_err_cnt;
`endif
    start = rdy_cnt;
    spi_xfer(16'h2468, 16, 15, -1, 16'h0, resp);
    end_frame();
    tick(12);
    checks++;
    if (rdy_cnt - start != 0) begin
      failures++;
      $display("FAIL short_rdy_count got=%0d exp=0", rdy_cnt - start);
    end
    checks++;
    if (rx_data !== 16'hFFFF) begin
      failures++;
      $display("FAIL short_rx_hold got=%h exp=ffff", rx_data);
    end
`ifdef SPI_SERF_FRAME_ERR_EN
    checks++;
    if (frm_err_cnt - estart != 1) begin
      failures++;
      $display("FAIL short_frm_err got=%0d exp=1", frm_err_cnt - estart);
    end
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL short_err_cnt got=%0d exp=1", err_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [15:0] resp;
    int          start;
    start   = rdy_cnt;
    tx_data = 16'h5555;
    spi_xfer(16'hCAFE, 16, 8, -1, 16'h0, resp);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    tick(1);
    rst_n = 1'b1;
    checks++;
    if (MISO !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_miso got=%b exp=0", MISO);
    end
    tick(12);
    checks++;
    if (rdy_cnt - start != 0 || rx_data !== 16'h0000) begin
      failures++;
      $display("FAIL rstmid_abort got=rdy%0d/%h exp=rdy0/0000", rdy_cnt - start, rx_data);
    end
`ifdef SPI_SERF_FRAME_ERR_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_err_cnt got=%0d exp=0", err_cnt);
    end
`endif
    spi_xfer(16'h1234, 16, 16, -1, 16'h0, resp);
    end_frame();
    tick(12);
    checks++;
    if (rdy_cnt - start != 1) begin
      failures++;
      $display("FAIL rstmid_rdy_count got=%0d exp=1", rdy_cnt - start);
    end
    checks++;
    if (rx_data !== 16'h1234) begin
      failures++;
      $display("FAIL rstmid_rx_data got=%h exp=1234", rx_data);
    end
    checks++;
    if (resp !== 16'h5555) begin
      failures++;
      $display("FAIL rstmid_miso_resp got=%h exp=5555", resp);
    end
  endtask

  task automatic test_tx_change();
    logic [15:0] resp;
    tx_data = 16'h0F0F;
    tick(2);
    spi_xfer(16'h6789, 16, 16, 5, 16'hF0F0, resp);
    end_frame();
    tick(12);
    checks++;
    if (resp !== 16'h0F0F) begin
      failures++;
      $display("FAIL txchg_miso_resp got=%h exp=0f0f", resp);
    end
    checks++;
    if (rx_data !== 16'h6789) begin
      failures++;
      $display("FAIL txchg_rx_data got=%h exp=6789", rx_data);
    end
  endtask

  task automatic test_min_period();
    logic [15:0] resp;
    int          start;
    start   = rdy_cnt;
    tx_data = 16'hC0DE;
    tick(2);
    spi_xfer(16'hBEEF, 4, 16, -1, 16'h0, resp);
    end_frame();
    tick(12);
    checks++;
    if (rdy_cnt - start != 1) begin
      failures++;
      $display("FAIL minper_rdy_count got=%0d exp=1", rdy_cnt - start);
    end
    checks++;
    if (rx_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL minper_rx_data got=%h exp=beef", rx_data);
    end
    checks++;
    if (resp !== 16'hC0DE) begin
      failures++;
      $display("FAIL minper_miso_resp got=%h exp=c0de", resp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rdy_cnt  = 0;
`ifdef SPI_SERF_FRAME_ERR_EN
    frm_err_cnt = 0;
`endif
    rst_n   = 1'b0;
    SS_n    = 1'b1;
    SCLK    = 1'b1;
    MOSI    = 1'b0;
    tx_data = 16'h0000;

    test_reset();
    test_basic();
    test_back_to_back();
    test_short_frame();
    test_reset_mid();
    test_tx_change();
    test_min_period();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spi_serf
